// File: rtl/csa_resolve.sv
// Carry-propagate resolver: folds a carry-save sum/carry pair into one binary word,
// resolving chunk_p bits per clock so the critical path is a single chunk_p-bit adder.
module csa_resolve #(
    parameter int width_p = 16,
    parameter int chunk_p = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [width_p-1:0] s_i,
    input  logic [width_p-1:0] c_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [width_p-1:0] res_o,
    output logic [1:0]         state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // in_ready_o and out_valid_o decode the state register only, so neither depends
    // combinationally on in_valid_i or out_ready_i.

    localparam int n_lp   = width_p / chunk_p;
    localparam int k_w_lp = (n_lp > 1) ? $clog2(n_lp) : 1;
    localparam int sum_w_lp = chunk_p + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_r, state_n;
    logic [width_p-1:0]  s_r, c_r, res_r, res_n;
    logic [k_w_lp-1:0]   k_r;
    logic                carry_r;
    logic                accept, last;
    logic [chunk_p-1:0]  s_ch, c_ch;
    logic [chunk_p:0]    sum_ch;

    assign accept = in_valid_i && in_ready_o;
    assign last   = (k_r == k_w_lp'(n_lp - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (accept)      state_n = BUSY;
            BUSY:    if (last)        state_n = DONE;
            DONE:    if (out_ready_i) state_n = IDLE;
            default:                  state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_r == IDLE);
        out_valid_o = (state_r == DONE);
        state_o     = state_r;
    end

    // Select chunk k of both operands, add with the rippled carry, merge into the result.
    always_comb begin
        s_ch  = '0;
        c_ch  = '0;
        res_n = res_r;
        for (int i = 0; i < n_lp; i++) begin
            if (k_r == k_w_lp'(i)) begin
                s_ch = s_r[i*chunk_p +: chunk_p];
                c_ch = c_r[i*chunk_p +: chunk_p];
            end
        end
        sum_ch = {1'b0, s_ch} + {1'b0, c_ch} + sum_w_lp'(carry_r);
        for (int i = 0; i < n_lp; i++) begin
            if (k_r == k_w_lp'(i)) res_n[i*chunk_p +: chunk_p] = sum_ch[chunk_p-1:0];
        end
    end

    // The carry vector is pre-shifted at accept; its MSB falls off, giving the mod 2^width wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r     <= '0;
            c_r     <= '0;
            res_r   <= '0;
            k_r     <= '0;
            carry_r <= 1'b0;
        end else if (accept) begin
            s_r     <= s_i;
            c_r     <= c_i << 1;
            k_r     <= '0;
            carry_r <= 1'b0;
        end else if (state_r == BUSY) begin
            res_r   <= res_n;
            carry_r <= sum_ch[chunk_p];
            k_r     <= last ? '0 : k_r + k_w_lp'(1);
        end
    end

    assign res_o = res_r;

endmodule
